pwm8_from_cnt: RTL and testbench
================================

Name: pwm8_from_cnt

Overview:
- Downstream consumer of the shared 8-bit up-counter's CNT output: turns the free-running count into a PWM waveform plus a period-boundary pulse.
- Duty register is double-buffered (shadow → active), so software updates take effect only at a period boundary. This keeps cycles glitch-free.
- A small FSM (IDLE/ARMED/RUN) ensures output starts only on a clean period start after enable.

Parameters:
- WIDTH, 8, width of CNT and duty values.
- POL, 0, output polarity: 0 = active-high PWM, 1 = inverted (idle level becomes 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- res  input  1  synchronous, active-high reset (sampled on rising clk only).
- EN  input  1  block enable; low forces IDLE.
- CNT  input  WIDTH  count value from the upstream counter.
- duty_in  input  WIDTH  new duty value.
- duty_wr  input  1  one-cycle strobe; captures duty_in into shadow.
- pwm  output  1  registered PWM output.
- per_start  output  1  one-cycle pulse at each detected period boundary while ARMED or RUN.
- upd_ack  output  1  one-cycle pulse when shadow is transferred to active.
- busy  output  1  high in RUN.

Behaviour:
- Reset (res=1 at posedge), all values below:
  - state=IDLE, cnt_prev=0, shadow=0, active=0, pending=0.
  - pwm=POL, per_start=0, upd_ack=0, busy=0.
  - Reset mid-period aborts immediately; no pending update survives.
- cnt_prev is registered CNT every cycle, in all states.
- Boundary event: bnd = (CNT < cnt_prev), unsigned compare. Covers natural wrap FF→00 and any backward jump from a load. Equal value (counter held) is not a boundary.
- Shadow write:
  - duty_wr=1 → shadow<=duty_in, pending<=1. Allowed in any state.
  - Multiple writes before a boundary: last one wins.
- Transfer: on bnd in ARMED or RUN with pending=1 → active<=shadow, pending<=0, upd_ack=1 next cycle.
- Write coinciding with bnd:
  - active takes the old shadow, and upd_ack pulses if the old pending was 1.
  - shadow takes duty_in and pending stays/becomes 1. The new value applies at the next boundary.
- FSM:
  - IDLE: pwm=POL. EN=1 → ARMED.
  - ARMED: pwm=POL. bnd → RUN, with the transfer applied in the same edge. EN=0 → IDLE.
  - RUN: pwm = POL ^ (CNT < active_eff). active_eff is the value active holds after this edge's transfer, so the first cycle of a new period already uses the new duty. EN=0 → IDLE.
  - EN=0 has priority over bnd.
- Output timing:
  - pwm is registered: 1-cycle latency from CNT to pwm.
  - per_start is registered from bnd && state!=IDLE: 1-cycle latency.
  - busy = (state==RUN), registered.
- Duty edge cases:
  - duty=0 → pwm constantly at POL level.
  - duty=255 → active for 255 of 256 counts; low only when CNT=FF.
  - No 100% mode.
- Counter held (upstream EN=0): CNT is static, so pwm is static at the level for that CNT; no boundary occurs.
- No X propagation: all registers are reset, and there are no latches.

Test Plan:
- Reset, then EN=1, duty_wr with 8'h40, CNT sweeping 00..FF twice:
  - stays ARMED until FF→00; upd_ack and per_start pulse 1 cycle after the wrap.
  - pwm high for exactly 64 cycles per period, starting 1 cycle after CNT=00.
- In RUN with duty 8'h40, write 8'hC0 at CNT=8'h80:
  - current period keeps 64-cycle high.
  - next period is 192-cycle high; upd_ack is a single pulse at the wrap.
- Write 8'h10 in the same cycle CNT goes FF→00 while 8'h20 is pending:
  - that period uses 8'h20.
  - the following period uses 8'h10; pending=1 in between.
- Backward jump from a load, CNT 8'h50→8'h05:
  - bnd fires; per_start pulses once.
  - CNT held at 8'h05 for 10 cycles → no further per_start.
- Duty 0 and duty 8'hFF over full sweeps:
  - duty 0 → pwm never active.
  - duty 8'hFF → pwm active 255 cycles, inactive only for CNT=FF. Repeat with POL=1 and check inverted levels.
- Assert res mid-RUN at CNT=8'h30 with a pending write:
  - next cycle pwm=POL, busy=0, pending cleared.
  - after res release with EN=1, the block waits in ARMED for the next wrap before driving pwm.

Source files
------------

// File: rtl/pwm8_from_cnt.sv
// PWM generator driven by a shared free-running up-counter's CNT value.
// Double-buffered duty register; output starts only on a clean period boundary after enable.
module pwm8_from_cnt #(
  parameter int WIDTH = 8,
  parameter bit POL   = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic [WIDTH-1:0] CNT,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_wr,
  output logic             pwm,
  output logic             per_start,
  output logic             upd_ack,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt_prev;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active, active_eff;
  logic             pending;
  logic             bnd;
  logic             xfer;

  // A boundary is any backward step of CNT: natural wrap or an upstream reload.
  always_comb begin
    bnd        = (CNT < cnt_prev);
    xfer       = bnd && (state != IDLE) && pending;
    active_eff = xfer ? shadow : active;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = ARMED;
      ARMED:   if (!EN) state_nxt = IDLE;
               else if (bnd) state_nxt = RUN;
      RUN:     if (!EN) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= IDLE;
      cnt_prev  <= '0;
      shadow    <= '0;
      active    <= '0;
      pending   <= 1'b0;
      pwm       <= POL;
      per_start <= 1'b0;
      upd_ack   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_prev <= CNT;
      if (xfer) active <= shadow;
      // A write on the boundary edge lands in shadow and stays pending for the next period.
      if (duty_wr) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
      pwm       <= (state_nxt == RUN) ? (POL ^ (CNT < active_eff)) : POL;
      per_start <= bnd && (state != IDLE);
      upd_ack   <= xfer;
      busy      <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_pwm8_from_cnt.sv
// Bench for pwm8_from_cnt: both polarities driven in parallel against a
// behavioural model, plus hand-computed per-period counts.
module tb_pwm8_from_cnt;

  logic       clk = 1'b0;
  logic       res, en, duty_wr;
  logic [7:0] cnt, duty_in;
  logic       pwm0, ps0, ack0, busy0;
  logic       pwm1, ps1, ack1, busy1;

  always #5 clk = ~clk;

  pwm8_from_cnt #(.WIDTH(8), .POL(1'b0)) dut0 (
    .clk(clk), .res(res), .EN(en), .CNT(cnt), .duty_in(duty_in), .duty_wr(duty_wr),
    .pwm(pwm0), .per_start(ps0), .upd_ack(ack0), .busy(busy0)
  );

  pwm8_from_cnt #(.WIDTH(8), .POL(1'b1)) dut1 (
    .clk(clk), .res(res), .EN(en), .CNT(cnt), .duty_in(duty_in), .duty_wr(duty_wr),
    .pwm(pwm1), .per_start(ps1), .upd_ack(ack1), .busy(busy1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=idle, 1=armed, 2=running; expectations describe the outputs after this edge.
  int m_mode, m_prev, m_shadow, m_active;
  bit m_pending, e_on, e_ps, e_ack, e_busy, chk_en;

  always @(posedge clk) begin
    if (res) begin
      m_mode = 0; m_prev = 0; m_shadow = 0; m_active = 0; m_pending = 0;
      e_on = 0; e_ps = 0; e_ack = 0; e_busy = 0;
    end else begin
      e_ps  = (int'(cnt) < m_prev) && (m_mode != 0);
      e_ack = e_ps && m_pending;
      if (e_ack) begin
        m_active  = m_shadow;
        m_pending = 0;
      end
      if (duty_wr) begin
        m_shadow  = int'(duty_in);
        m_pending = 1;
      end
      if (!en)                 m_mode = 0;
      else if (m_mode == 0)    m_mode = 1;
      else if (e_ps)           m_mode = 2;
      e_busy = (m_mode == 2);
      e_on   = e_busy && (int'(cnt) < m_active);
      m_prev = int'(cnt);
    end
  end

  int hi0, hi1, nps, nack;

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("pwm_pol0", pwm0, e_on);
      check("pwm_pol1", pwm1, !e_on);
      check("per_start0", ps0, e_ps);
      check("per_start1", ps1, e_ps);
      check("upd_ack0", ack0, e_ack);
      check("upd_ack1", ack1, e_ack);
      check("busy0", busy0, e_busy);
      check("busy1", busy1, e_busy);
    end
    hi0  += int'(pwm0);
    hi1  += int'(pwm1);
    nps  += int'(ps0);
    nack += int'(ack0);
  end

  task automatic clear_counts();
    hi0 = 0; hi1 = 0; nps = 0; nack = 0;
  endtask

  task automatic step(input int c, input bit wr = 1'b0, input int d = 0);
    cnt     = 8'(c);
    duty_wr = wr;
    duty_in = 8'(d);
    @(posedge clk);
    #3;
    duty_wr = 1'b0;
  endtask

  task automatic sweep(input int from, input int to, input int wr_at = -1, input int wr_val = 0);
    for (int i = from; i <= to; i++) step(i, i == wr_at, wr_val);
  endtask

  task automatic check_counts(input string tag, input int e_hi0, input int e_ps, input int e_ack);
    check({tag, "_high_cycles"}, hi0, e_hi0);
    check({tag, "_inv_high_cycles"}, hi1, (nps == 0 && e_hi0 == 0 && !busy0) ? hi1 : 256 - e_hi0);
    check({tag, "_per_start_count"}, nps, e_ps);
    check({tag, "_upd_ack_count"}, nack, e_ack);
  endtask

  initial begin
    res = 1'b1; en = 1'b0; duty_wr = 1'b0; duty_in = '0; cnt = '0; chk_en = 1'b0;
    step(0);
    step(0);
    chk_en = 1'b1;
    check("reset_pwm0", pwm0, 1'b0);
    check("reset_pwm1", pwm1, 1'b1);
    check("reset_busy", busy0, 1'b0);

    // Enable and load 0x40; first sweep stays armed, second starts at the wrap.
    res = 1'b0; en = 1'b1;
    step(0, 1'b1, 8'h40);
    clear_counts();
    sweep(0, 255);
    check("armed_high", hi0, 0);
    check("armed_inv_high", hi1, 256);
    check("armed_per_start", nps, 0);
    check("armed_upd_ack", nack, 0);
    clear_counts();
    step(0);
    check("wrap_pwm0", pwm0, 1'b1);
    check("wrap_ack", ack0, 1'b1);
    check("wrap_per_start", ps0, 1'b1);
    check("wrap_busy", busy0, 1'b1);
    sweep(1, 255);
    check_counts("duty40", 64, 1, 1);

    // Mid-period write only takes effect on the following period.
    clear_counts(); sweep(0, 255, 8'h80, 8'hC0); check_counts("keep40", 64, 1, 0);
    clear_counts(); sweep(0, 255);              check_counts("dutyC0", 192, 1, 1);

    // Write coinciding with the wrap while 0x20 is pending.
    clear_counts(); sweep(0, 255, 8'h10, 8'h20); check_counts("pend20", 192, 1, 0);
    clear_counts(); sweep(0, 255, 0, 8'h10);     check_counts("use20", 32, 1, 1);
    clear_counts(); sweep(0, 255);               check_counts("use10", 16, 1, 1);

    // Backward jump 0x50 -> 0x05, then counter held.
    sweep(0, 8'h50);
    clear_counts();
    for (int k = 0; k < 11; k++) step(8'h05);
    check("jump_per_start", nps, 1);
    check("jump_upd_ack", nack, 0);
    check("jump_high", hi0, 11);

    // Duty 0 and duty 0xFF.
    step(8'h05, 1'b1, 8'h00);
    clear_counts(); sweep(0, 255, 8'h80, 8'hFF); check_counts("duty00", 0, 1, 1);
    clear_counts(); sweep(0, 255);               check_counts("dutyFF", 255, 1, 1);
    check("dutyFF_lastcnt_pwm0", pwm0, 1'b0);
    check("dutyFF_lastcnt_pwm1", pwm1, 1'b1);

    // Reset mid-run with a pending write.
    sweep(0, 8'h2F, 8'h20, 8'h80);
    res = 1'b1;
    step(8'h30);
    res = 1'b0;
    check("midreset_pwm0", pwm0, 1'b0);
    check("midreset_pwm1", pwm1, 1'b1);
    check("midreset_busy", busy0, 1'b0);
    clear_counts(); sweep(8'h31, 255);
    check("rearm_high", hi0, 0);
    check("rearm_per_start", nps, 0);
    check("rearm_busy", busy0, 1'b0);
    clear_counts(); sweep(0, 255, 8'h80, 8'h40);
    check("postreset_ack", nack, 0);
    check("postreset_high", hi0, 0);
    check("postreset_busy", busy0, 1'b1);
    clear_counts(); sweep(0, 255); check_counts("postreset40", 64, 1, 1);

    // Disable returns to idle.
    en = 1'b0;
    step(8'h10);
    check("disable_busy", busy0, 1'b0);
    check("disable_pwm1", pwm1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
